axi4_burst_ram_slave: RTL and testbench

- AXI4 responder (slave) with an internal byte-addressable RAM.
- Serves the 128-bit AXI4 master that the block-level benches drive from the DPI side.
- Supports FIXED, INCR and WRAP bursts, narrow transfers, write strobes and SLVERR on out-of-range accesses.
- Read and write channels are independent; each has one outstanding burst.

---
 rtl/axi4_burst_ram_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_axi4_burst_ram_slave.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_ram_slave.sv
// AXI4 responder backed by a byte-lane RAM: FIXED/INCR/WRAP bursts, narrow beats,
// write strobes, SLVERR on bad commands or out-of-range beats. One burst per channel.
module axi4_burst_ram_slave #(
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    WORDS      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_axi_aw_valid,
    output logic                      io_axi_aw_ready,
    input  logic [ADDR_WIDTH-1:0]     io_axi_aw_payload_addr,
    input  logic [7:0]                io_axi_aw_payload_len,
    input  logic [2:0]                io_axi_aw_payload_size,
    input  logic [1:0]                io_axi_aw_payload_burst,
    input  logic                      io_axi_w_valid,
    output logic                      io_axi_w_ready,
    input  logic [DATA_WIDTH-1:0]     io_axi_w_payload_data,
    input  logic [DATA_WIDTH/8-1:0]   io_axi_w_payload_strb,
    input  logic                      io_axi_w_payload_last,
    output logic                      io_axi_b_valid,
    input  logic                      io_axi_b_ready,
    output logic [1:0]                io_axi_b_payload_resp,
    input  logic                      io_axi_ar_valid,
    output logic                      io_axi_ar_ready,
    input  logic [ADDR_WIDTH-1:0]     io_axi_ar_payload_addr,
    input  logic [7:0]                io_axi_ar_payload_len,
    input  logic [2:0]                io_axi_ar_payload_size,
    input  logic [1:0]                io_axi_ar_payload_burst,
    output logic                      io_axi_r_valid,
    input  logic                      io_axi_r_ready,
    output logic [DATA_WIDTH-1:0]     io_axi_r_payload_data,
    output logic [1:0]                io_axi_r_payload_resp,
    output logic                      io_axi_r_payload_last
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(WORDS);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic addr_t next_addr(addr_t addr, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        addr_t bytes;
        addr_t total;
        addr_t lower;
        addr_t inc;
        bytes = addr_t'(1) << size;
        total = (addr_t'(len) + addr_t'(1)) * bytes;
        lower = addr & ~(total - addr_t'(1));
        inc   = (addr & ~(bytes - addr_t'(1))) + bytes;
        case (burst)
            2'b01:   next_addr = inc;
            2'b10:   next_addr = (inc == lower + total) ? lower : inc;
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic cmd_bad(addr_t addr, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
        logic len_ok;
        logic aligned;
        len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        aligned = (addr & ((addr_t'(1) << size) - addr_t'(1))) == '0;
        cmd_bad = (size > 3'd4) || (burst == 2'b11) || ((burst == 2'b10) && !(len_ok && aligned));
    endfunction

    // The extra top bit of the offset catches addresses below BASE_ADDR.
    function automatic logic in_range(addr_t addr);
        logic [ADDR_WIDTH:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        in_range = !off[ADDR_WIDTH] && ((off >> 4) < (ADDR_WIDTH+1)'(WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(addr_t addr);
        word_idx = IDX_W'((addr - BASE_ADDR) >> 4);
    endfunction

    // ---------------- write channel ----------------
    wstate_t    w_state_q, w_state_d;
    addr_t      w_addr_q;
    logic [7:0] w_len_q, w_cnt_q;
    logic [2:0] w_size_q;
    logic [1:0] w_burst_q;
    logic       w_bad_q, w_err_q;

    always_comb begin
        w_state_d             = w_state_q;
        io_axi_aw_ready       = 1'b0;
        io_axi_w_ready        = 1'b0;
        io_axi_b_valid        = 1'b0;
        io_axi_b_payload_resp = 2'b00;
        case (w_state_q)
            W_IDLE: begin
                io_axi_aw_ready = 1'b1;
                if (io_axi_aw_valid) w_state_d = W_DATA;
            end
            W_DATA: begin
                io_axi_w_ready = 1'b1;
                if (io_axi_w_valid && (w_cnt_q == w_len_q)) w_state_d = W_RESP;
            end
            W_RESP: begin
                io_axi_b_valid        = 1'b1;
                io_axi_b_payload_resp = w_err_q ? 2'b10 : 2'b00;
                if (io_axi_b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    logic aw_fire, w_fire, w_beat_ok, w_we;
    assign aw_fire   = io_axi_aw_valid && io_axi_aw_ready;
    assign w_fire    = io_axi_w_valid && io_axi_w_ready;
    assign w_beat_ok = !w_bad_q && in_range(w_addr_q);
    assign w_we      = w_fire && w_beat_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_fire) begin
                w_addr_q  <= io_axi_aw_payload_addr;
                w_len_q   <= io_axi_aw_payload_len;
                w_size_q  <= io_axi_aw_payload_size;
                w_burst_q <= io_axi_aw_payload_burst;
                w_cnt_q   <= '0;
                w_bad_q   <= cmd_bad(io_axi_aw_payload_addr, io_axi_aw_payload_len,
                                     io_axi_aw_payload_size, io_axi_aw_payload_burst);
                w_err_q   <= cmd_bad(io_axi_aw_payload_addr, io_axi_aw_payload_len,
                                     io_axi_aw_payload_size, io_axi_aw_payload_burst);
            end else if (w_fire) begin
                w_addr_q <= next_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
                w_cnt_q  <= w_cnt_q + 8'd1;
                if (!w_beat_ok || (io_axi_w_payload_last != (w_cnt_q == w_len_q)))
                    w_err_q <= 1'b1;
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t         r_state_q, r_state_d;
    addr_t           r_addr_q, r_next_addr, rd_addr;
    logic [7:0]      r_len_q, r_cnt_q;
    logic [2:0]      r_size_q;
    logic [1:0]      r_burst_q;
    logic            r_bad_q, rd_bad, rd_ok;
    logic [DATA_WIDTH-1:0] r_data_q, rd_word;
    logic [1:0]      r_resp_q;

    always_comb begin
        r_state_d             = r_state_q;
        io_axi_ar_ready       = 1'b0;
        io_axi_r_valid        = 1'b0;
        io_axi_r_payload_last = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                io_axi_ar_ready = 1'b1;
                if (io_axi_ar_valid) r_state_d = R_DATA;
            end
            R_DATA: begin
                io_axi_r_valid        = 1'b1;
                io_axi_r_payload_last = (r_cnt_q == r_len_q);
                if (io_axi_r_ready && (r_cnt_q == r_len_q)) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    logic ar_fire, r_adv;
    assign ar_fire     = io_axi_ar_valid && io_axi_ar_ready;
    assign r_adv       = io_axi_r_valid && io_axi_r_ready && !io_axi_r_payload_last;
    assign r_next_addr = next_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
    // The RAM is read for the beat that will be on the bus next cycle.
    assign rd_addr     = ar_fire ? io_axi_ar_payload_addr : r_next_addr;
    assign rd_bad      = ar_fire ? cmd_bad(io_axi_ar_payload_addr, io_axi_ar_payload_len,
                                           io_axi_ar_payload_size, io_axi_ar_payload_burst)
                                 : r_bad_q;
    assign rd_ok       = !rd_bad && in_range(rd_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                r_addr_q  <= io_axi_ar_payload_addr;
                r_len_q   <= io_axi_ar_payload_len;
                r_size_q  <= io_axi_ar_payload_size;
                r_burst_q <= io_axi_ar_payload_burst;
                r_cnt_q   <= '0;
                r_bad_q   <= rd_bad;
            end else if (r_adv) begin
                r_addr_q <= r_next_addr;
                r_cnt_q  <= r_cnt_q + 8'd1;
            end
            if (ar_fire || r_adv) begin
                r_data_q <= rd_ok ? rd_word : '0;
                r_resp_q <= rd_ok ? 2'b00 : 2'b10;
            end
        end
    end

    assign io_axi_r_payload_data = r_data_q;
    assign io_axi_r_payload_resp = r_resp_q;

    // One byte-wide RAM per lane; a same-cycle read sees the pre-write contents.
    logic [IDX_W-1:0] w_idx, rd_idx;
    assign w_idx  = word_idx(w_addr_q);
    assign rd_idx = word_idx(rd_addr);

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            always_ff @(posedge clk) begin
                if (w_we && io_axi_w_payload_strb[gi])
                    mem[w_idx] <= io_axi_w_payload_data[8*gi +: 8];
            end
            assign rd_word[8*gi +: 8] = mem[rd_idx];
        end
    endgenerate
endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Scoreboard bench: drivers push predicted R beats / B responses from a byte-level
// model of the RAM; a monitor compares them whenever the DUT presents R or B.
module tb_axi4_burst_ram_slave;
    localparam int          WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic         ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0]  aw_addr, ar_addr;
    logic [7:0]   aw_len, ar_len;
    logic [2:0]   aw_size, ar_size;
    logic [1:0]   aw_burst, ar_burst, b_resp, r_resp;
    logic [127:0] w_data, r_data;
    logic [15:0]  w_strb;

    axi4_burst_ram_slave #(.DATA_WIDTH(128), .ADDR_WIDTH(32), .WORDS(WORDS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(rst_n),
        .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
        .io_axi_aw_payload_addr(aw_addr), .io_axi_aw_payload_len(aw_len),
        .io_axi_aw_payload_size(aw_size), .io_axi_aw_payload_burst(aw_burst),
        .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
        .io_axi_w_payload_data(w_data), .io_axi_w_payload_strb(w_strb), .io_axi_w_payload_last(w_last),
        .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready), .io_axi_b_payload_resp(b_resp),
        .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
        .io_axi_ar_payload_addr(ar_addr), .io_axi_ar_payload_len(ar_len),
        .io_axi_ar_payload_size(ar_size), .io_axi_ar_payload_burst(ar_burst),
        .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready), .io_axi_r_payload_data(r_data),
        .io_axi_r_payload_resp(r_resp), .io_axi_r_payload_last(r_last)
    );

    typedef struct {
        logic [127:0] data;
        logic [127:0] mask;
        logic [1:0]   resp;
        logic         last;
    } rexp_t;

    rexp_t       rexp_q[$];
    logic [1:0]  bexp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    logic [7:0]   mem_m   [WORDS*16];
    bit           known_m [WORDS*16];
    logic [127:0] wdata_tab [256];
    logic [15:0]  wstrb_tab [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit cmd_bad_m(logic [31:0] a, int len, int size, int burst);
        if (size > 4 || burst == 3) return 1'b1;
        if (burst == 2) begin
            if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
            if ((longint'(a) % (longint'(1) << size)) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] beat_addr_m(logic [31:0] a, int len, int size, int burst, int i);
        longint la, bytes, total, lower;
        la    = longint'(a);
        bytes = longint'(1) << size;
        total = longint'(len + 1) * bytes;
        case (burst)
            1: return (i == 0) ? a : 32'((la / bytes) * bytes + longint'(i) * bytes);
            2: begin
                lower = (la / total) * total;
                return 32'(lower + ((la - lower) + longint'(i) * bytes) % total);
            end
            default: return a;
        endcase
    endfunction

    function automatic bit in_range_m(logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(WORDS) * 16);
    endfunction

    function automatic int byte_base_m(logic [31:0] a);
        return int'(((longint'(a) - longint'(BASE)) / 16) * 16);
    endfunction

    task automatic predict_read(input logic [31:0] a, input int len, input int size, input int burst);
        rexp_t e;
        logic [31:0] ba;
        bit bad;
        int bb;
        bad = cmd_bad_m(a, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            ba = beat_addr_m(a, len, size, burst, i);
            e.last = (i == len);
            if (bad || !in_range_m(ba)) begin
                e.data = '0; e.mask = '1; e.resp = 2'b10;
            end else begin
                bb = byte_base_m(ba);
                e.resp = 2'b00;
                for (int j = 0; j < 16; j++) begin
                    e.data[8*j +: 8] = mem_m[bb + j];
                    e.mask[8*j +: 8] = known_m[bb + j] ? 8'hFF : 8'h00;
                end
            end
            rexp_q.push_back(e);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic wait_ready(input int which, output bit ok);
        bit r;
        r  = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            r = (which == 0) ? aw_ready : (which == 1) ? w_ready : ar_ready;
            @(posedge clk); #1;
            if (r) begin ok = 1'b1; break; end
        end
        if (!ok) check("handshake_timeout", 128'(r), 128'(1));
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input int size, input int burst,
                            input bit early_last);
        bit err, bad, ok, lastv;
        logic [31:0] ba;
        int bb, cyc;
        bad = cmd_bad_m(a, len, size, burst);
        err = bad;
        for (int i = 0; i <= len; i++) begin
            ba    = beat_addr_m(a, len, size, burst, i);
            lastv = early_last ? (i == 0) : (i == len);
            if (lastv != (i == len)) err = 1'b1;
            if (!bad) begin
                if (!in_range_m(ba)) err = 1'b1;
                else begin
                    bb = byte_base_m(ba);
                    for (int j = 0; j < 16; j++)
                        if (wstrb_tab[i][j]) begin
                            mem_m[bb + j]   = wdata_tab[i][8*j +: 8];
                            known_m[bb + j] = 1'b1;
                        end
                end
            end
        end
        bexp_q.push_back(err ? 2'b10 : 2'b00);
        $display("WR addr=%h len=%0d size=%0d burst=%0d expect_resp=%0d", a, len, size, burst, err ? 2 : 0);
        aw_addr = a; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst); aw_valid = 1'b1;
        wait_ready(0, ok);
        aw_valid = 1'b0;
        if (!ok) begin bexp_q.delete(); return; end
        for (int i = 0; i <= len; i++) begin
            if ($urandom % 4 == 0) begin
                w_valid = 1'b0;
                @(posedge clk); #1;
            end
            w_data = wdata_tab[i]; w_strb = wstrb_tab[i];
            w_last = early_last ? (i == 0) : (i == len);
            w_valid = 1'b1;
            wait_ready(1, ok);
            if (!ok) break;
        end
        w_valid = 1'b0; w_last = 1'b0;
        cyc = 0;
        b_ready = ($urandom % 2 == 0);
        while (bexp_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            b_ready = ($urandom % 3 != 0);
            cyc++;
        end
        b_ready = 1'b0;
        if (bexp_q.size() != 0) begin
            check("b_timeout", 128'(bexp_q.size()), 128'(0));
            bexp_q.delete();
        end
    endtask

    // mode 0: random r_ready; 1: r_ready always high, latency checked; 2: stall 5 cycles after 2 beats
    task automatic do_read(input logic [31:0] a, input int len, input int size, input int burst, input int mode);
        bit ok;
        int cyc, popped, stall;
        predict_read(a, len, size, burst);
        $display("RD addr=%h len=%0d size=%0d burst=%0d mode=%0d", a, len, size, burst, mode);
        ar_addr = a; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst); ar_valid = 1'b1;
        r_ready = (mode == 0) ? ($urandom % 2 == 0) : 1'b1;
        wait_ready(2, ok);
        ar_valid = 1'b0;
        if (!ok) begin rexp_q.delete(); r_ready = 1'b0; return; end
        cyc = 0; stall = 5;
        while (rexp_q.size() != 0 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            popped = len + 1 - rexp_q.size();
            if (mode == 2 && popped == 2 && stall > 0) begin
                r_ready = 1'b0;
                stall--;
            end else r_ready = (mode == 0) ? ($urandom % 3 != 0) : 1'b1;
        end
        r_ready = 1'b0;
        if (rexp_q.size() != 0) begin
            check("r_timeout", 128'(rexp_q.size()), 128'(0));
            rexp_q.delete();
        end else if (mode == 1) check("r_beats_cycles", 128'(cyc), 128'(len + 1));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && r_valid) begin
            if (rexp_q.size() == 0) check("r_unexpected_valid", 128'(r_valid), 128'(0));
            else begin
                check("r_data", r_data & rexp_q[0].mask, rexp_q[0].data & rexp_q[0].mask);
                check("r_resp", 128'(r_resp), 128'(rexp_q[0].resp));
                check("r_last", 128'(r_last), 128'(rexp_q[0].last));
                if (r_ready) void'(rexp_q.pop_front());
            end
        end
        if (rst_n && b_valid && b_ready) begin
            if (bexp_q.size() == 0) check("b_unexpected_valid", 128'(b_valid), 128'(0));
            else check("b_resp", 128'(b_resp), 128'(bexp_q.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int len, size, burst, cyc;
        rst_n = 1'b0;
        aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
        for (int i = 0; i < WORDS*16; i++) begin mem_m[i] = 8'h00; known_m[i] = 1'b0; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", 128'(aw_ready), 128'(1));
        check("rst_ar_ready", 128'(ar_ready), 128'(1));
        check("rst_w_ready",  128'(w_ready),  128'(0));
        check("rst_b_valid",  128'(b_valid),  128'(0));
        check("rst_r_valid",  128'(r_valid),  128'(0));
        check("rst_r_data",   r_data,         128'(0));
        check("rst_r_last",   128'(r_last),   128'(0));
        check("rst_b_resp",   128'(b_resp),   128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_aw_ready", 128'(aw_ready), 128'(1));
        check("post_rst_ar_ready", 128'(ar_ready), 128'(1));
        check("post_rst_w_ready",  128'(w_ready),  128'(0));
        check("post_rst_r_valid",  128'(r_valid),  128'(0));
        check("post_rst_b_valid",  128'(b_valid),  128'(0));

        // INCR write then read at full rate
        for (int i = 0; i < 4; i++) begin
            wdata_tab[i] = 128'h0123_4567_89AB_CDEF_0011_2233_4455_66A0 + 128'(i);
            wstrb_tab[i] = 16'hFFFF;
        end
        do_write(32'h100, 3, 4, 1, 1'b0);
        do_read(32'h100, 3, 4, 1, 1);

        // WRAP read order 0x60, 0x70, 0x40, 0x50
        for (int i = 0; i < 4; i++) begin wdata_tab[i] = 128'(i); wstrb_tab[i] = 16'hFFFF; end
        do_write(32'h40, 3, 4, 1, 1'b0);
        do_read(32'h60, 3, 4, 2, 1);

        // strobes with FIXED over a known background word
        wdata_tab[0] = {$urandom, $urandom, $urandom, $urandom}; wstrb_tab[0] = 16'hFFFF;
        do_write(32'h200, 0, 4, 1, 1'b0);
        wdata_tab[0] = '1;            wstrb_tab[0] = 16'h000F;
        wdata_tab[1] = {16{8'hAA}};   wstrb_tab[1] = 16'hF000;
        do_write(32'h200, 1, 4, 0, 1'b0);
        do_read(32'h200, 0, 4, 1, 1);

        // backpressure, out-of-range write, early w_last
        do_read(32'h100, 3, 4, 1, 2);
        wstrb_tab[0] = 16'hFFFF; wdata_tab[0] = '1;
        do_write(32'(WORDS * 16), 0, 4, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin wdata_tab[i] = {4{$urandom}}; wstrb_tab[i] = 16'hFFFF; end
        do_write(32'h300, 2, 4, 1, 1'b1);
        do_read(32'h300, 2, 4, 1, 0);

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            burst = ($urandom % 10 == 0) ? 3 : int'($urandom % 3);
            size  = ($urandom % 12 == 0) ? 5 + int'($urandom % 3) : int'($urandom % 5);
            if (burst == 2 && $urandom % 4 != 0) begin
                case ($urandom % 4)
                    0: len = 1; 1: len = 3; 2: len = 7; default: len = 15;
                endcase
            end else len = int'($urandom % 8);
            if ($urandom % 8 == 0) a = 32'(WORDS * 16 - 64) + ($urandom % 128);
            else a = $urandom % 4096;
            if (burst == 2 && size <= 4 && $urandom % 4 != 0) a = a & ~((32'd1 << size) - 32'd1);
            if ($urandom % 2 == 0) begin
                for (int i = 0; i <= len; i++) begin
                    wdata_tab[i] = {$urandom, $urandom, $urandom, $urandom};
                    wstrb_tab[i] = 16'($urandom);
                end
                do_write(a, len, size, burst, 1'b0);
            end else do_read(a, len, size, burst, 0);
        end

        // reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) begin wdata_tab[i] = {4{$urandom}}; wstrb_tab[i] = 16'hFFFF; end
        do_write(32'h400, 7, 4, 1, 1'b0);
        predict_read(32'h400, 7, 4, 1);
        $display("RD addr=%h len=7 size=4 burst=1 interrupted by reset", 32'h400);
        ar_addr = 32'h400; ar_len = 8'd7; ar_size = 3'd4; ar_burst = 2'd1; ar_valid = 1'b1;
        r_ready = 1'b1;
        begin
            bit ok;
            wait_ready(2, ok);
        end
        ar_valid = 1'b0;
        cyc = 0;
        while (rexp_q.size() > 6 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        check("pre_reset_beats_left", 128'(rexp_q.size()), 128'(6));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_r_valid", 128'(r_valid), 128'(0));
        check("midrst_r_last",  128'(r_last),  128'(0));
        rexp_q.delete();
        r_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_midrst_ar_ready", 128'(ar_ready), 128'(1));
        check("after_midrst_r_valid",  128'(r_valid),  128'(0));
        do_read(32'h400, 7, 4, 1, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
